// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch buffer.
// The fetch entry's pc field is PC_W wide, so the top-level AW must equal PC_W.
package if_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          PC_W     = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic            misalign;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Synchronous FIFO with flush; the head is read straight from the registered storage array.
module if_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  // A flush wins over any pop or push arriving in the same cycle.
  assign do_pop  = pop & valid & ~flush;
  assign do_push = push & ~flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/if_fetch_buf.sv
// Fetch stage: one outstanding imem read per PC, responses buffered for decode.
// Optional IF_FETCH_ALIGN_CHECK_EN turns a misaligned PC into a local NOP entry flagged on id_misalign.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = PC_W
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [AW-1:0] pc_i,
  output logic          pc_stall,
  input  logic          redirect_i,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_inst,
  output logic [AW-1:0] id_pc
`ifdef IF_FETCH_ALIGN_CHECK_EN
  , output logic        id_misalign
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [AW-1:0] req_pc;
  logic [CW-1:0] count;
  logic          room, issue, accept, rsp_push, push;
  fetch_entry_t  wdata, head;

  // Any non-IDLE state holds the single outstanding request.
  assign room     = (int'(count) + int'(state != IDLE)) < DEPTH;
  assign issue    = RST & (state == IDLE) & room & ~redirect_i;
  assign rsp_push = (state == WAIT) & imem_rvalid & ~redirect_i;
  assign accept   = imem_req & imem_gnt;
  assign pc_stall = ~accept;
  assign imem_addr = pc_i;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic halt, misalign, local_push;
  assign misalign   = (pc_i[1:0] != 2'b00);
  assign imem_req   = issue & ~halt & ~misalign;
  assign local_push = issue & ~halt & misalign;
  assign push       = rsp_push | local_push;
  assign wdata      = local_push ? fetch_entry_t'{pc: pc_i, inst: NOP_INST, misalign: 1'b1}
                                 : fetch_entry_t'{pc: req_pc, inst: imem_rdata, misalign: 1'b0};
  assign id_misalign = head.misalign;

  // After the NOP marker is queued, fetch sits idle until the next redirect.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)            halt <= 1'b0;
    else if (redirect_i) halt <= 1'b0;
    else if (local_push) halt <= 1'b1;
  end
`else
  logic unused_misalign;
  assign imem_req        = issue;
  assign push            = rsp_push;
  assign wdata           = fetch_entry_t'{pc: req_pc, inst: imem_rdata, misalign: 1'b0};
  assign unused_misalign = head.misalign;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_pc <= pc_i;
          state  <= WAIT;
        end
        // rvalid together with redirect retires the request; its data is simply not pushed.
        WAIT: if (imem_rvalid)     state <= IDLE;
              else if (redirect_i) state <= DROP;
        DROP: if (imem_rvalid)     state <= IDLE;
        default:                   state <= IDLE;
      endcase
    end
  end

  if_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (RST),
    .flush (redirect_i),
    .push  (push),
    .wdata (wdata),
    .pop   (id_ready),
    .rdata (head),
    .valid (id_valid),
    .count (count)
  );

  assign id_inst = head.inst;
  assign id_pc   = head.pc;
endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed vector tables, hand-written corner sequences, and a random run against a queue-based model.
module tb_if_fetch_buf;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          RST;
  logic [AW-1:0] pc_i;
  logic          pc_stall, redirect_i, imem_req, imem_gnt, imem_rvalid;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata, id_inst;
  logic          id_valid, id_ready;
  logic [AW-1:0] id_pc;
`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic          id_misalign;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .RST         (RST),
    .pc_i        (pc_i),
    .pc_stall    (pc_stall),
    .redirect_i  (redirect_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
`ifdef IF_FETCH_ALIGN_CHECK_EN
    , .id_misalign (id_misalign)
`endif
  );

  typedef struct {
    logic        rs;
    logic        redir, gnt, rvalid, ready;
    logic [31:0] pc, rdata;
    logic        e_req, e_stall, e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, redir, gnt, rvalid, ready,
                              input logic [31:0] pc, rdata,
                              input logic er, es, ev, input logic [31:0] epc, einst);
    vec_t v;
    v.rs = rs; v.redir = redir; v.gnt = gnt; v.rvalid = rvalid; v.ready = ready;
    v.pc = pc; v.rdata = rdata;
    v.e_req = er; v.e_stall = es; v.e_valid = ev; v.e_pc = epc; v.e_inst = einst;
    return v;
  endfunction

  function automatic logic [31:0] dword(input int i);
    return 32'hD000_0000 + i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req"},   32'(imem_req), 32'd0);
    chk({nm, "_stall"}, 32'(pc_stall), 32'd1);
    chk({nm, "_valid"}, 32'(id_valid), 32'd0);
    chk({nm, "_inst"},  id_inst,       32'd0);
    chk({nm, "_pc"},    id_pc,         32'd0);
  endtask

  task automatic idle_inputs();
    redirect_i = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    id_ready = 1'b0; pc_i = '0; imem_rdata = '0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    chk_reset_vals("rst");
    @(negedge clk);
    RST = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge and check outputs before the rising edge.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    redirect_i = v.redir; imem_gnt = v.gnt; imem_rvalid = v.rvalid;
    id_ready = v.ready; pc_i = v.pc; imem_rdata = v.rdata;
    #2;
    chk({nm, "_req"},   32'(imem_req), 32'(v.e_req));
    chk({nm, "_stall"}, 32'(pc_stall), 32'(v.e_stall));
    chk({nm, "_valid"}, 32'(id_valid), 32'(v.e_valid));
    if (v.e_req) chk({nm, "_addr"}, imem_addr, v.pc);
    if (v.e_valid) begin
      chk({nm, "_idpc"},   id_pc,   v.e_pc);
      chk({nm, "_idinst"}, id_inst, v.e_inst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    ent_t        q[$];
    bit          pend, drop;
    logic [31:0] ppc, mpc;
    vec_t        v;

    RST = 1'b0;
    idle_inputs();

    // Reset / basic fetch: gnt, rvalid next cycle, output two cycles after gnt
    tbl.push_back(mk(1,0,1,0,1, 32'h0,  32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,1,1, 32'h4,  32'h2000_0001, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,0,0,1, 32'h4,  32'h0,         1,1,1, 32'h0, 32'h2000_0001));
    tbl.push_back(mk(0,0,0,0,1, 32'h4,  32'h0,         1,1,0, 32'h0, 32'h0));
    // Back-pressure: two entries fill the buffer, then drain in order and resume at 0x8
    tbl.push_back(mk(1,0,1,0,0, 32'h0,  32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,1,0, 32'h4,  32'h1111_0000, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,0,0, 32'h4,  32'h0,         1,0,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(0,0,1,1,0, 32'h8,  32'h1111_0004, 0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(0,0,1,0,0, 32'h8,  32'h0,         0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(0,0,1,0,0, 32'h8,  32'h0,         0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(0,0,1,0,1, 32'h8,  32'h0,         0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(0,0,1,0,1, 32'h8,  32'h0,         1,0,1, 32'h4, 32'h1111_0004));
    tbl.push_back(mk(0,0,1,1,1, 32'hC,  32'h1111_0008, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,0,0,1, 32'hC,  32'h0,         1,1,1, 32'h8, 32'h1111_0008));
    tbl.push_back(mk(0,0,0,0,1, 32'hC,  32'h0,         1,1,0, 32'h0, 32'h0));
    // Redirect in WAIT -> DROP (second redirect holds DROP), stale data dropped, refetch at 0x100
    tbl.push_back(mk(1,0,1,0,1, 32'h10, 32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,1,0,0,1, 32'h14, 32'h0,         0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,1,1,0,1, 32'h18, 32'h0,         0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,1,1, 32'h100,32'hDEAD_BEEF, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,0,1, 32'h100,32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,0,1,1, 32'h104,32'h3333_0100, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,0,0,1, 32'h104,32'h0,         1,1,1, 32'h100, 32'h3333_0100));
    // Redirect coincident with rvalid, then redirect flushing a valid head
    tbl.push_back(mk(1,0,1,0,0, 32'h20, 32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,1,1,1,0, 32'h24, 32'hBAD0_0024, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,1,0,0, 32'h200,32'h0,         1,0,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,0,1,0, 32'h204,32'hAAAA_0001, 0,1,0, 32'h0, 32'h0));
    tbl.push_back(mk(0,1,1,0,1, 32'h204,32'h0,         0,1,1, 32'h200, 32'hAAAA_0001));
    tbl.push_back(mk(0,0,0,0,1, 32'h300,32'h0,         1,1,0, 32'h0, 32'h0));

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rs) do_reset();
      apply(tbl[k], $sformatf("tbl%0d", k));
    end

    // Full with simultaneous push/pop: one buffered + one outstanding, ten wrap iterations
    do_reset();
    apply(mk(0,0,1,0,0, 32'h400, 32'h0,    1,0,0, 32'h0,   32'h0),    "e_f0");
    apply(mk(0,0,0,1,0, 32'h404, dword(0), 0,1,0, 32'h0,   32'h0),    "e_f1");
    apply(mk(0,0,1,0,0, 32'h404, 32'h0,    1,0,1, 32'h400, dword(0)), "e_f2");
    for (int i = 0; i < 10; i++) begin
      apply(mk(0,0,0,1,1, 32'h400 + 4*(i+2), dword(i+1), 0,1,1, 32'h400 + 4*i,     dword(i)),
            $sformatf("e_pp%0d", i));
      apply(mk(0,0,1,0,0, 32'h400 + 4*(i+2), 32'h0,      1,0,1, 32'h400 + 4*(i+1), dword(i+1)),
            $sformatf("e_is%0d", i));
    end

    // Async reset mid-WAIT with a buffered entry, then a stale rvalid
    do_reset();
    apply(mk(0,0,1,0,0, 32'h500, 32'h0,         1,0,0, 32'h0,   32'h0),         "f0");
    apply(mk(0,0,0,1,0, 32'h504, 32'h5555_0500, 0,1,0, 32'h0,   32'h0),         "f1");
    apply(mk(0,0,1,0,0, 32'h504, 32'h0,         1,0,1, 32'h500, 32'h5555_0500), "f2");
    @(posedge clk); #2;
    RST = 1'b0;
    idle_inputs();
    #1;
    chk_reset_vals("f_async");
    @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    apply(mk(0,0,0,1,0, 32'h600, 32'hBAD0_0000, 1,1,0, 32'h0,   32'h0),         "f_stale");
    apply(mk(0,0,0,0,0, 32'h600, 32'h0,         1,1,0, 32'h0,   32'h0),         "f_after");
    apply(mk(0,0,1,0,1, 32'h600, 32'h0,         1,0,0, 32'h0,   32'h0),         "f_go");
    apply(mk(0,0,0,1,1, 32'h604, 32'h6666_0600, 0,1,0, 32'h0,   32'h0),         "f_rsp");
    apply(mk(0,0,0,0,1, 32'h604, 32'h0,         1,1,1, 32'h600, 32'h6666_0600), "f_out");

    // Random traffic against a queue model: one outstanding fetch, drop-after-redirect
    do_reset();
    q.delete();
    pend = 1'b0; drop = 1'b0; ppc = '0; mpc = '0;
    for (int n = 0; n < 600; n++) begin
      v = mk(0,0,0,0,0, 32'h0, 32'h0, 0,0,0, 32'h0, 32'h0);
      v.redir  = ($urandom_range(0, 9) == 0);
      v.gnt    = 1'($urandom_range(0, 1));
      v.rvalid = 1'($urandom_range(0, 1));
      v.ready  = ($urandom_range(0, 2) != 0);
      v.pc     = mpc;
      v.rdata  = $urandom;
      v.e_valid = (q.size() != 0);
      if (v.e_valid) begin
        v.e_pc   = q[0].pc;
        v.e_inst = q[0].inst;
      end
      v.e_req   = !pend && (q.size() < DEPTH) && !v.redir;
      v.e_stall = !(v.e_req && v.gnt);
      apply(v, $sformatf("rnd%0d", n));

      if (v.redir) q.delete();
      else if (q.size() != 0 && v.ready) void'(q.pop_front());
      if (pend && v.rvalid) begin
        if (!drop && !v.redir) q.push_back('{pc: ppc, inst: v.rdata});
        pend = 1'b0;
        drop = 1'b0;
      end else if (pend && v.redir) begin
        drop = 1'b1;
      end
      if (v.e_req && v.gnt) begin
        pend = 1'b1;
        drop = 1'b0;
        ppc  = mpc;
      end
      if (v.redir)                 mpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (v.e_req && v.gnt)   mpc = mpc + 32'd4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues one word read per PC to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode with valid/ready.
- Back-pressures the next-PC mux via pc_stall and drops in-flight fetches on redirect.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- AW, 32, PC/address width.

Ports:
- clk  in  1  rising-edge clock.
- RST  in  1  asynchronous active-low reset.
- pc_i  in  AW  current PC from PC register.
- pc_stall  out  1  1 = upstream must hold PC (pc1 = pc2).
- redirect_i  in  1  branch/jump taken; flush all fetch state this cycle.
- imem_req  out  1  read request valid.
- imem_addr  out  AW  request address (= pc_i when issued).
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  decode accepts head.
- id_inst  out  32  head instruction.
- id_pc  out  AW  head PC.

Behaviour:
- Reset (RST=0, async): FSM=IDLE, FIFO empty, imem_req=0, id_valid=0, pc_stall=1, id_inst=0, id_pc=0.
- Room rule: count + outstanding < DEPTH, where outstanding in {0,1}. At most one outstanding request.
- FSM states:
  - IDLE: imem_req = room & ~redirect_i; imem_addr = pc_i. On imem_gnt, latch pc_i into req_pc and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, push {req_pc, imem_rdata} and go to IDLE. If redirect_i is asserted, go to DROP instead (when rvalid coincides with redirect, go to IDLE and discard the data).
  - DROP: discard the next imem_rvalid, then go to IDLE. A further redirect_i in DROP stays in DROP.
- pc_stall = ~(imem_req & imem_gnt): the PC advances exactly once per accepted request. redirect_i overrides at the PC mux, outside this block.
- Push/pop:
  - Pop when id_valid & id_ready.
  - Simultaneous push and pop at full is legal (count unchanged). Push cannot occur at full due to the room rule.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- redirect_i (synchronous, same cycle):
  - FIFO cleared (pointers and count to 0) and id_valid=0 next cycle.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is ignored.
- Latency: request accepted at cycle T with rvalid at T+k gives id_valid=1 at T+k+1. FIFO outputs are registered from the storage array.
- imem_rvalid in IDLE (protocol error) is ignored.
- Reset mid-operation clears everything; any later rvalid is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: IF_FETCH_ALIGN_CHECK_EN.
- Defined:
  - Each FIFO entry carries a misalign bit; extra output id_misalign (1 bit).
  - If pc_i[1:0] != 0 in IDLE with room, no memory request is issued. Instead a local entry {pc_i, 32'h0000_0013 (nop), misalign=1} is pushed, pc_stall=1, and the FSM stays in IDLE, idle until redirect.
- Undefined:
  - No alignment check; imem_addr = pc_i unmodified; no id_misalign port.

Decomposition:
- Package if_pkg:
  - fetch_state_t enum (IDLE, WAIT, DROP).
  - NOP_INST = 32'h0000_0013.
  - fetch_entry_t struct {pc, inst, misalign}.
- One sub-module: if_fifo (parameterised sync FIFO with flush, push/pop, count), instantiated once; FSM and handshake logic live in the top level.

Test Plan:
- Reset/basic:
  - Stimulus: RST low, then high; pc_i=0x0, gnt=1, rvalid one cycle later with 0x2000_0001; id_ready=1.
  - Response: imem_req in the first cycle after reset; id_valid with id_pc=0x0, id_inst=0x2000_0001 two cycles after gnt.
- Back-pressure:
  - Stimulus: id_ready=0, continuous gnt/rvalid, pc_i=0x0, 0x4, 0x8.
  - Response: exactly DEPTH=2 entries (0x0, 0x4) buffered; imem_req=0 and pc_stall=1 thereafter. id_ready=1 drains in order, then fetching of 0x8 resumes.
- Redirect in WAIT:
  - Stimulus: gnt for 0x10, redirect_i next cycle, rvalid one cycle later.
  - Response: FSM enters DROP, data discarded, FIFO empty; the next request carries the new pc_i (e.g. 0x100).
- Redirect coincident with rvalid:
  - Stimulus: redirect and rvalid in the same cycle.
  - Response: no push; FSM goes to IDLE; id_valid=0.
- Full with simultaneous push/pop:
  - Stimulus: FIFO at count=1 plus one outstanding request; rvalid and id_ready together.
  - Response: count stays 1, order preserved, pointers wrap correctly over 10 iterations.
- Async reset mid-WAIT:
  - Stimulus: RST low between clock edges, then high; stale rvalid arrives.
  - Response: outputs at reset values immediately; stale rvalid ignored; id_valid stays 0.
